// File: rtl/ppm_if.sv
// Result port of the pulse parameter meter: timestamps, overflow flag and
// a valid/ready handshake. The meter drives through master, the consumer through slave.
interface ppm_if #(
  parameter int WIDTH = 16
) ();
  logic [WIDTH-1:0] t_rise;
  logic [WIDTH-1:0] t_fall;
  logic             valid;
  logic             ready;
  logic             ovf;

  modport master (
    output t_rise,
    output t_fall,
    output valid,
    output ovf,
    input  ready
  );

  modport slave (
    input  t_rise,
    input  t_fall,
    input  valid,
    input  ovf,
    output ready
  );
endinterface

// File: rtl/ppm_unit.sv
// Pulse parameter meter: timestamps the first rise and following fall of din
// in cycles after trig. Define PPM_FILTER_EN to add a FILT_LEN-sample glitch filter.
//
// state | meaning
// IDLE  | no measurement, waiting for trig
// ARMED | counter running, waiting for a synchronized 0->1
// HIGH  | rise captured, waiting for a synchronized 1->0
// DONE  | result presented on the port until valid&&ready
module ppm_unit #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic  clk,
  input  logic  rstn,
  input  logic  trig,
  input  logic  din,
  ppm_if.master res,
  output logic  missed,
  output logic  busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_HIGH  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Cycles between a din sample at the first sync flop and the edge that
  // latches its timestamp, minus one; subtracted from the counter at capture.
`ifdef PPM_FILTER_EN
  localparam int LAT = SYNC_STAGES - 1 + FILT_LEN - 1;
`else
  localparam int LAT = SYNC_STAGES - 1;
`endif
  localparam logic [WIDTH-1:0] LAT_W   = WIDTH'(LAT);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || FILT_LEN < 1) begin : g_param_check
      $error("ppm_unit: SYNC_STAGES must be 2..4 and FILT_LEN at least 1");
    end
  endgenerate

  logic [1:0]             state_q, state_d;
  logic [WIDTH-1:0]       cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   filt_q, filt_d;
  logic [WIDTH-1:0]       t_rise_q, t_rise_d;
  logic [WIDTH-1:0]       t_fall_q, t_fall_d;
  logic                   ovf_q, ovf_d;
  logic                   missed_q, missed_d;

  logic                   raw;
  logic                   evt;
  logic                   valid;
  logic                   hs;
  logic                   trig_ok;
  logic                   sat;
  logic                   early;
  logic [WIDTH-1:0]       ts;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    raw    = sync_q[SYNC_STAGES-1];
  end

`ifdef PPM_FILTER_EN
  localparam int RUN_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [RUN_W-1:0] run_q, run_d;

  // run_q counts consecutive samples differing from the filtered level;
  // the FILT_LEN-th such sample flips the level and raises evt.
  always_comb begin
    run_d  = '0;
    filt_d = filt_q;
    evt    = 1'b0;
    if (raw != filt_q) begin
      if (run_q == RUN_W'(FILT_LEN - 1)) begin
        evt    = 1'b1;
        filt_d = raw;
      end else begin
        run_d = run_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) run_q <= '0;
    else       run_q <= run_d;
  end
`else
  always_comb begin
    filt_d = raw;
    evt    = (raw != filt_q);
  end
`endif

  always_comb begin
    valid   = (state_q == ST_DONE);
    hs      = valid & res.ready;
    trig_ok = trig & (~valid | hs);
    sat     = (cnt_q == CNT_MAX);
    // Edges sampled before the arming edge must not count as a rise.
    early   = (cnt_q < LAT_W);
    ts      = cnt_q - LAT_W;

    state_d  = state_q;
    t_rise_d = t_rise_q;
    t_fall_d = t_fall_q;
    ovf_d    = ovf_q;
    missed_d = missed_q;

    if (trig_ok)  cnt_d = '0;
    else if (sat) cnt_d = cnt_q;
    else          cnt_d = cnt_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (trig) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (trig) begin
          state_d = ST_ARMED;
        end else if (sat) begin
          state_d  = ST_DONE;
          ovf_d    = 1'b1;
          t_rise_d = CNT_MAX;
          t_fall_d = CNT_MAX;
        end else if (evt && raw && !early) begin
          state_d  = ST_HIGH;
          t_rise_d = ts;
        end
      end
      ST_HIGH: begin
        if (trig) begin
          state_d = ST_ARMED;
        end else if (sat) begin
          state_d  = ST_DONE;
          ovf_d    = 1'b1;
          t_fall_d = CNT_MAX;
        end else if (evt && !raw) begin
          state_d  = ST_DONE;
          t_fall_d = ts;
        end
      end
      ST_DONE: begin
        if (hs) begin
          ovf_d    = 1'b0;
          missed_d = 1'b0;
          state_d  = trig ? ST_ARMED : ST_IDLE;
        end else if (trig) begin
          missed_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sync_q   <= '0;
      filt_q   <= 1'b0;
      t_rise_q <= '0;
      t_fall_q <= '0;
      ovf_q    <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sync_q   <= sync_d;
      filt_q   <= filt_d;
      t_rise_q <= t_rise_d;
      t_fall_q <= t_fall_d;
      ovf_q    <= ovf_d;
      missed_q <= missed_d;
    end
  end

  assign res.t_rise = t_rise_q;
  assign res.t_fall = t_fall_q;
  assign res.valid  = valid;
  assign res.ovf    = ovf_q;
  assign missed     = missed_q;
  assign busy       = (state_q == ST_ARMED) || (state_q == ST_HIGH);

endmodule

// File: doc/ppm_unit.md
Name: ppm_unit

Overview:
- Pulse parameter meter; the capture-side counterpart of the ppg_unit pulse generator.
- On trig, starts a cycle counter, then timestamps the first rising edge and the following falling edge of an asynchronous input din.
- Reports both timestamps in the same units as the generator's tdelay/tpulse (cycles after trig), through a valid/ready result port.
- Used for loopback self-test of PPG channels and for timing externally generated strobes.

Parameters:
- WIDTH, 16, width of counter and reported timestamps.
- SYNC_STAGES, 2, synchronizer flops on din (legal range 2..4).
- FILT_LEN, 3, glitch-filter length in cycles; used only when PPM_FILTER_EN is defined.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- trig  in  1  start measurement (synchronous, single-cycle)
- din  in  1  asynchronous pulse input
- t_rise  out  WIDTH  rising-edge timestamp
- t_fall  out  WIDTH  falling-edge timestamp
- valid  out  1  result available
- ready  in  1  result consumed when valid&&ready
- ovf  out  1  counter saturated before measurement completed
- missed  out  1  sticky: trig arrived while a result was pending
- busy  out  1  state is ARMED or HIGH

Behaviour:
- Reset: state IDLE, counter 0, synchronizer 0, t_rise/t_fall 0, valid/ovf/missed/busy 0.
- Timebase: counter is loaded with 0 on the edge that samples trig, then increments by 1 every cycle.
- Timestamp rule: a transition sampled by the first synchronizer flop at the edge where counter==N reports N.
  - Implementation subtracts the synchronizer latency (SYNC_STAGES-1) at detection.
  - A din edge exactly N cycles after trig therefore reports N, matching ppg tdelay/tpulse semantics.
- State IDLE: busy=0; trig -> ARMED.
- State ARMED: waits for a synchronized 0->1 transition.
  - din already high when armed is not a rise; a falling and then rising transition is required.
  - On rise: latch t_rise -> HIGH.
- State HIGH: on a synchronized 1->0 transition, latch t_fall -> DONE.
- State DONE: valid=1; t_rise, t_fall and ovf are held stable until valid&&ready, then -> IDLE.
- Retrigger: trig in ARMED or HIGH restarts the measurement (counter=0, state ARMED); the partial result is discarded.
- trig in DONE without a same-cycle handshake: ignored, missed set to 1.
  - missed clears on the next handshake, unless a new ignored trig occurs in that same cycle.
- trig in the same cycle as valid&&ready: the handshake completes and the trig is accepted -> ARMED.
- Overflow: counter saturates at all-ones (never wraps). On reaching all-ones in ARMED or HIGH:
  - -> DONE with ovf=1.
  - Any timestamp not yet captured is reported as all-ones.
- Rise and fall at the same edge are impossible after synchronization; a 1-cycle pulse reports t_fall = t_rise + 1.
- Reset asserted mid-operation: immediate return to reset values; the pending result is lost.
- Latency: valid rises SYNC_STAGES cycles after the din falling edge is first sampled.

Optional Feature:
- PPM_FILTER_EN defined: a transition is accepted only after FILT_LEN consecutive equal synchronized samples.
  - Timestamp is that of the first sample of the run; the extra latency is compensated, so the reported values are unchanged.
  - Pulses or gaps shorter than FILT_LEN cycles are ignored.
  - valid is delayed by a further FILT_LEN-1 cycles.
- PPM_FILTER_EN undefined: no filter logic; every synchronized transition counts; FILT_LEN is unused.

Test Plan:
- Basic capture: ready=1, trig, din high 5 cycles after trig, low 12 cycles after trig -> t_rise=5, t_fall=12, valid for exactly 1 cycle, ovf=0.
- Backpressure and missed: ready=0 after a result is pending, trig pulsed twice -> t_rise/t_fall held stable and missed=1; then ready=1 -> handshake, missed=0, state IDLE.
- Retrigger and pre-high: din high at trig, retrigger at cycle 3, din low at cycle 6 and high at cycle 8, low at cycle 10 (times relative to the second trig) -> t_rise=8, t_fall=10.
- Overflow: WIDTH=8, trig, din never rises -> valid with ovf=1, t_rise=t_fall=255.
- Same-cycle trig and handshake, then reset mid-op: trig together with valid&&ready -> busy next cycle; rstn low while in HIGH -> all outputs 0 and no valid afterwards.
- PPM_FILTER_EN with FILT_LEN=3: a 2-cycle glitch at cycle 4, then a real pulse from cycle 10 to cycle 20 -> t_rise=10, t_fall=20.
